// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the three-requester memory port arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  localparam int NUM_REQ = 3;

  localparam logic [1:0] REQ_FETCH  = 2'd0;
  localparam logic [1:0] REQ_DREAD  = 2'd1;
  localparam logic [1:0] REQ_DWRITE = 2'd2;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/select/handshake bundle between the core control and the memory port arbiter.
interface mem_port_arbiter_if;
  import arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               sel_first;
  logic               sel_second;
  logic               sel_third;
  logic               mem_en;
  logic [NUM_REQ-1:0] ack;
  logic               busy;

  modport master (
    output req,
    input  sel_first, sel_second, sel_third, mem_en, ack, busy
  );

  modport slave (
    input  req,
    output sel_first, sel_second, sel_third, mem_en, ack, busy
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin pick: searches upward from the requester after last, with wrap.
module rr_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic [1:0]         winner,
  output logic               any_req
);

  always_comb begin
    // NOTE: outputs are assigned before the case so no path leaves them unassigned (no latch).
    winner  = REQ_FETCH;
    any_req = |req;
    case (last)
      REQ_FETCH:
        winner = req[REQ_DREAD]  ? REQ_DREAD  : (req[REQ_DWRITE] ? REQ_DWRITE : REQ_FETCH);
      REQ_DREAD:
        winner = req[REQ_DWRITE] ? REQ_DWRITE : (req[REQ_FETCH]  ? REQ_FETCH  : REQ_DREAD);
      default:
        winner = req[REQ_FETCH]  ? REQ_FETCH  : (req[REQ_DREAD]  ? REQ_DREAD  : REQ_DWRITE);
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer for one shared fixed-latency memory port with three requesters.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ACCESS_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  localparam int CNT_W = (ACCESS_CYCLES < 2) ? 1 : $clog2(ACCESS_CYCLES + 1);

  arb_state_t         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_last;
  logic [NUM_REQ-1:0] r_sel;
  logic [NUM_REQ-1:0] r_ack;
  logic               r_mem_en;
  logic               r_busy;

  logic [1:0]         w_winner;
  logic               w_any_req;

  rr_pick u_pick (
    .req     (bus.req),
    .last    (r_last),
    .winner  (w_winner),
    .any_req (w_any_req)
  );

  // NOTE: all state uses non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_last   <= REQ_DWRITE;
      r_sel    <= '0;
      r_ack    <= '0;
      r_mem_en <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state  <= ACCESS;
            r_sel    <= NUM_REQ'(3'b001 << w_winner);
            r_mem_en <= 1'b1;
            r_busy   <= 1'b1;
            r_cnt    <= CNT_W'(ACCESS_CYCLES - 1);
            r_last   <= w_winner;
          end
        end
        ACCESS: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            // Select is one-hot on the winner, so it doubles as the ack vector.
            r_state  <= DONE;
            r_mem_en <= 1'b0;
            r_ack    <= r_sel;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_sel   <= '0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state  <= IDLE;
          r_sel    <= '0;
          r_mem_en <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel_first  = r_sel[REQ_FETCH];
  assign bus.sel_second = r_sel[REQ_DREAD];
  assign bus.sel_third  = r_sel[REQ_DWRITE];
  assign bus.mem_en     = r_mem_en;
  assign bus.ack        = r_ack;
  assign bus.busy       = r_busy;

endmodule
